// File: rtl/mipi_rx_pkt_assembler.sv
// mipi_rx_pkt_assembler
// Assembles framed, checksummed packets of DLEN payload bytes from multi-beat
// MIPI RX data (rx_pixel_clk domain) and presents each finished packet through
// a valid/ready holding register. A packet is a header beat (byte0 == SYNC,
// byte1 = sequence), ceil(DLEN/BPB) payload beats and a trailer beat whose
// byte0 is the XOR of all payload bytes. All beats must be on the same VC.
//
// Ports:
//   rx_pixel_clk     - sole clock, rising edge
//   rst              - synchronous active-high reset
//   vc_ena           - per-virtual-channel header accept mask
//   my_mipi_rx_VALID - beat qualifier
//   my_mipi_rx_DATA  - beat data, byte i at [8i+7:8i], low BPB bytes used
//   my_mipi_rx_VC    - virtual channel of the beat
//   data_ready       - downstream takes the held packet
//   data             - held payload, byte k at [8k+7:8k]
//   data_vc/data_seq - VC and sequence byte of the held packet
//   data_valid       - holding register full
//   data_available   - one-cycle pulse when a packet is loaded
//   busy             - assembler is mid-packet
//   crc_err_cnt, drop_cnt, ovf_cnt, tmo_cnt - saturating error counters
module mipi_rx_pkt_assembler #(
  parameter int          DLEN    = 64,
  parameter int          BPB     = 6,
  parameter logic [7:0]  SYNC    = 8'h7E,
  parameter int          TIMEOUT = 1024
) (
  input  logic                rx_pixel_clk,
  input  logic                rst,
  input  logic [3:0]          vc_ena,
  input  logic                my_mipi_rx_VALID,
  input  logic [63:0]         my_mipi_rx_DATA,
  input  logic [1:0]          my_mipi_rx_VC,
  input  logic                data_ready,
  output logic [DLEN*8-1:0]   data,
  output logic [1:0]          data_vc,
  output logic [7:0]          data_seq,
  output logic                data_valid,
  output logic                data_available,
  output logic                busy,
  output logic [7:0]          crc_err_cnt,
  output logic [7:0]          drop_cnt,
  output logic [7:0]          ovf_cnt,
  output logic [7:0]          tmo_cnt
);

  localparam int NBEATS = (DLEN + BPB - 1) / BPB;
  localparam int BCW    = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int TCW    = $clog2(TIMEOUT);
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(NBEATS - 1);
  localparam logic [TCW-1:0] TMO_LAST  = TCW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_CHECK} state_t;

  state_t              state_q, state_d;
  logic [1:0]          vc_q, vc_d;
  logic [7:0]          seq_q, seq_d;
  logic [BCW-1:0]      beat_cnt_q, beat_cnt_d;
  logic [7:0]          xor_q, xor_d;
  logic [TCW-1:0]      idle_cnt_q, idle_cnt_d;
  logic [DLEN*8-1:0]   pay_q, pay_d;
  logic [DLEN*8-1:0]   data_q, data_d;
  logic [1:0]          data_vc_q, data_vc_d;
  logic [7:0]          data_seq_q, data_seq_d;
  logic                data_valid_q, data_valid_d;
  logic                data_available_q, data_available_d;
  logic                busy_q, busy_d;
  logic [7:0]          crc_q, crc_d, drop_q, drop_d, ovf_q, ovf_d, tmo_q, tmo_d;

  logic [7:0] byte0;
  logic       beat_mine;
  logic       rel;
  wire        unused_data = ^my_mipi_rx_DATA;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign byte0     = my_mipi_rx_DATA[7:0];
  assign beat_mine = my_mipi_rx_VALID && (my_mipi_rx_VC == vc_q);
  assign rel       = data_valid_q && data_ready;

  always_comb begin
    state_d          = state_q;
    vc_d             = vc_q;
    seq_d            = seq_q;
    beat_cnt_d       = beat_cnt_q;
    xor_d            = xor_q;
    idle_cnt_d       = idle_cnt_q;
    pay_d            = pay_q;
    data_d           = data_q;
    data_vc_d        = data_vc_q;
    data_seq_d       = data_seq_q;
    data_valid_d     = data_valid_q && !rel;
    data_available_d = 1'b0;
    crc_d            = crc_q;
    drop_d           = drop_q;
    ovf_d            = ovf_q;
    tmo_d            = tmo_q;

    case (state_q)
      S_IDLE: begin
        if (my_mipi_rx_VALID && byte0 == SYNC && vc_ena[my_mipi_rx_VC]) begin
          vc_d       = my_mipi_rx_VC;
          seq_d      = my_mipi_rx_DATA[15:8];
          beat_cnt_d = '0;
          xor_d      = 8'h00;
          idle_cnt_d = '0;
          state_d    = S_PAYLOAD;
        end
      end
      default: begin
        if (beat_mine) begin
          idle_cnt_d = '0;
          if (state_q == S_PAYLOAD) begin
            // Each payload byte k belongs to beat k/BPB at lane k%BPB; lanes
            // past DLEN in the final beat never match and so are ignored.
            for (int k = 0; k < DLEN; k++) begin
              if (k / BPB == int'(beat_cnt_q)) begin
                pay_d[8*k +: 8] = my_mipi_rx_DATA[8*(k%BPB) +: 8];
                xor_d           = xor_d ^ my_mipi_rx_DATA[8*(k%BPB) +: 8];
              end
            end
            beat_cnt_d = beat_cnt_q + 1'b1;
            if (beat_cnt_q == LAST_BEAT) state_d = S_CHECK;
          end else begin
            state_d = S_IDLE;
            if (byte0 == xor_q) begin
              // A release on this same edge frees the register for the load.
              if (!data_valid_q || rel) begin
                data_d           = pay_q;
                data_vc_d        = vc_q;
                data_seq_d       = seq_q;
                data_valid_d     = 1'b1;
                data_available_d = 1'b1;
              end else begin
                ovf_d = sat_inc(ovf_q);
              end
            end else begin
              crc_d = sat_inc(crc_q);
            end
          end
        end else begin
          if (my_mipi_rx_VALID) drop_d = sat_inc(drop_q);
          if (idle_cnt_q == TMO_LAST) begin
            tmo_d   = sat_inc(tmo_q);
            state_d = S_IDLE;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge rx_pixel_clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      vc_q             <= '0;
      seq_q            <= '0;
      beat_cnt_q       <= '0;
      xor_q            <= '0;
      idle_cnt_q       <= '0;
      pay_q            <= '0;
      data_q           <= '0;
      data_vc_q        <= '0;
      data_seq_q       <= '0;
      data_valid_q     <= 1'b0;
      data_available_q <= 1'b0;
      busy_q           <= 1'b0;
      crc_q            <= '0;
      drop_q           <= '0;
      ovf_q            <= '0;
      tmo_q            <= '0;
    end else begin
      state_q          <= state_d;
      vc_q             <= vc_d;
      seq_q            <= seq_d;
      beat_cnt_q       <= beat_cnt_d;
      xor_q            <= xor_d;
      idle_cnt_q       <= idle_cnt_d;
      pay_q            <= pay_d;
      data_q           <= data_d;
      data_vc_q        <= data_vc_d;
      data_seq_q       <= data_seq_d;
      data_valid_q     <= data_valid_d;
      data_available_q <= data_available_d;
      busy_q           <= busy_d;
      crc_q            <= crc_d;
      drop_q           <= drop_d;
      ovf_q            <= ovf_d;
      tmo_q            <= tmo_d;
    end
  end

  assign data           = data_q;
  assign data_vc        = data_vc_q;
  assign data_seq       = data_seq_q;
  assign data_valid     = data_valid_q;
  assign data_available = data_available_q;
  assign busy           = busy_q;
  assign crc_err_cnt    = crc_q;
  assign drop_cnt       = drop_q;
  assign ovf_cnt        = ovf_q;
  assign tmo_cnt        = tmo_q;

endmodule

// File: tb/tb_mipi_rx_pkt_assembler.sv
// tb_mipi_rx_pkt_assembler
// Drives whole packets (random payload bytes) into the assembler configured
// with a partial final beat (DLEN=10, BPB=6) and a short timeout. Expected
// outputs come from a packet-level model: payload is a byte array, checksum
// is its XOR, and each trailer either loads, overflows or counts a CRC error.
module tb_mipi_rx_pkt_assembler;

  localparam int DLEN    = 10;
  localparam int BPB     = 6;
  localparam int TIMEOUT = 16;
  localparam int NBEATS  = (DLEN + BPB - 1) / BPB;

  logic                rx_pixel_clk = 1'b0;
  logic                rst;
  logic [3:0]          vc_ena;
  logic                my_mipi_rx_VALID;
  logic [63:0]         my_mipi_rx_DATA;
  logic [1:0]          my_mipi_rx_VC;
  logic                data_ready;
  logic [DLEN*8-1:0]   data;
  logic [1:0]          data_vc;
  logic [7:0]          data_seq;
  logic                data_valid;
  logic                data_available;
  logic                busy;
  logic [7:0]          crc_err_cnt, drop_cnt, ovf_cnt, tmo_cnt;

  int errors = 0;
  int checks = 0;

  // Packet-level reference model state
  logic [7:0]        pay [DLEN];
  logic [DLEN*8-1:0] exp_data;
  logic [1:0]        exp_vc;
  logic [7:0]        exp_seq;
  logic              exp_valid;
  logic              exp_avail;
  logic [7:0]        exp_crc, exp_drop, exp_ovf, exp_tmo;

  mipi_rx_pkt_assembler #(
    .DLEN(DLEN), .BPB(BPB), .SYNC(8'h7E), .TIMEOUT(TIMEOUT)
  ) dut (
    .rx_pixel_clk    (rx_pixel_clk),
    .rst             (rst),
    .vc_ena          (vc_ena),
    .my_mipi_rx_VALID(my_mipi_rx_VALID),
    .my_mipi_rx_DATA (my_mipi_rx_DATA),
    .my_mipi_rx_VC   (my_mipi_rx_VC),
    .data_ready      (data_ready),
    .data            (data),
    .data_vc         (data_vc),
    .data_seq        (data_seq),
    .data_valid      (data_valid),
    .data_available  (data_available),
    .busy            (busy),
    .crc_err_cnt     (crc_err_cnt),
    .drop_cnt        (drop_cnt),
    .ovf_cnt         (ovf_cnt),
    .tmo_cnt         (tmo_cnt)
  );

  always #5 rx_pixel_clk = ~rx_pixel_clk;

  // Hard stop in case the stimulus ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // One beat (or idle cycle) presented for exactly one rising edge; outputs
  // are then sampled 1 time unit after that edge.
  task automatic applyStimulus(input logic v, input logic [1:0] vc, input logic [63:0] d);
    my_mipi_rx_VALID = v;
    my_mipi_rx_VC    = vc;
    my_mipi_rx_DATA  = d;
    @(posedge rx_pixel_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, "_valid"}, 128'(data_valid), 128'(exp_valid));
    checkOutput({tag, "_avail"}, 128'(data_available), 128'(exp_avail));
    checkOutput({tag, "_busy"}, 128'(busy), 128'(0));
    checkOutput({tag, "_crc"}, 128'(crc_err_cnt), 128'(exp_crc));
    checkOutput({tag, "_drop"}, 128'(drop_cnt), 128'(exp_drop));
    checkOutput({tag, "_ovf"}, 128'(ovf_cnt), 128'(exp_ovf));
    checkOutput({tag, "_tmo"}, 128'(tmo_cnt), 128'(exp_tmo));
    if (exp_valid) begin
      checkOutput({tag, "_data"}, 128'(data), 128'(exp_data));
      checkOutput({tag, "_vc"}, 128'(data_vc), 128'(exp_vc));
      checkOutput({tag, "_seq"}, 128'(data_seq), 128'(exp_seq));
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_data"}, 128'(data), 128'(0));
    checkOutput({tag, "_vc"}, 128'(data_vc), 128'(0));
    checkOutput({tag, "_seq"}, 128'(data_seq), 128'(0));
    checkOutput({tag, "_valid"}, 128'(data_valid), 128'(0));
    checkOutput({tag, "_avail"}, 128'(data_available), 128'(0));
    checkOutput({tag, "_busy"}, 128'(busy), 128'(0));
    checkOutput({tag, "_cnts"}, 128'({crc_err_cnt, drop_cnt, ovf_cnt, tmo_cnt}), 128'(0));
  endtask

  task automatic clearModel();
    exp_data  = '0;
    exp_vc    = '0;
    exp_seq   = '0;
    exp_valid = 1'b0;
    exp_avail = 1'b0;
    exp_crc   = '0;
    exp_drop  = '0;
    exp_ovf   = '0;
    exp_tmo   = '0;
  endtask

  // Full packet: header, payload beats (random junk in unused lanes), an
  // optional foreign-VC beat after the first payload beat, then trailer with
  // data_ready held at rdy for that cycle only.
  task automatic sendPacket(input logic [1:0] vc, input logic [7:0] seq, input bit bad,
                            input bit rdy, input bit foreign);
    logic [7:0]  x;
    logic [63:0] d;
    logic [7:0]  tr;
    bit          rel;
    bit          loaded;
    x = 8'h00;
    for (int k = 0; k < DLEN; k++) begin
      pay[k] = 8'($urandom);
      x      = x ^ pay[k];
    end
    applyStimulus(1'b1, vc, {$urandom(), 16'($urandom), seq, 8'h7E});
    checkOutput("busy_after_hdr", 128'(busy), 128'(1));
    for (int b = 0; b < NBEATS; b++) begin
      d = {$urandom(), $urandom()};
      for (int j = 0; j < BPB; j++)
        if (b * BPB + j < DLEN) d[8*j +: 8] = pay[b*BPB + j];
      applyStimulus(1'b1, vc, d);
      if (foreign && b == 0) applyStimulus(1'b1, vc ^ 2'd1, {$urandom(), $urandom()});
    end
    tr = bad ? (x ^ (8'h01 << $urandom_range(0, 7))) : x;
    data_ready = rdy;
    applyStimulus(1'b1, vc, {$urandom(), 24'($urandom), tr});
    data_ready       = 1'b0;
    my_mipi_rx_VALID = 1'b0;

    rel    = exp_valid && rdy;
    loaded = 1'b0;
    if (!bad) begin
      if (!exp_valid || rel) begin
        for (int k = 0; k < DLEN; k++) exp_data[8*k +: 8] = pay[k];
        exp_vc  = vc;
        exp_seq = seq;
        loaded  = 1'b1;
      end else begin
        exp_ovf++;
      end
    end else begin
      exp_crc++;
    end
    if (foreign) exp_drop++;
    if (loaded) exp_valid = 1'b1;
    else if (rel) exp_valid = 1'b0;
    exp_avail = loaded;
  endtask

  task automatic releaseHeld();
    data_ready = 1'b1;
    applyStimulus(1'b0, 2'd0, 64'd0);
    data_ready = 1'b0;
    exp_valid  = 1'b0;
    exp_avail  = 1'b0;
    checkOutput("release_valid", 128'(data_valid), 128'(0));
  endtask

  initial begin
    logic [1:0] vcs [3];
    vcs = '{2'd0, 2'd1, 2'd3};
    rst              = 1'b1;
    vc_ena           = 4'b0000;
    data_ready       = 1'b0;
    my_mipi_rx_VALID = 1'b0;
    my_mipi_rx_VC    = 2'd0;
    my_mipi_rx_DATA  = 64'd0;
    clearModel();
    applyStimulus(1'b0, 2'd0, 64'd0);
    applyStimulus(1'b0, 2'd0, 64'd0);
    checkAllZero("reset");
    rst    = 1'b0;
    vc_ena = 4'b0001;

    $display("[TB] good packet on VC0");
    sendPacket(2'd0, 8'h01, 1'b0, 1'b0, 1'b0);
    checkState("good");
    applyStimulus(1'b0, 2'd0, 64'd0);
    exp_avail = 1'b0;
    checkState("good_hold");
    releaseHeld();

    $display("[TB] checksum error");
    sendPacket(2'd0, 8'h02, 1'b1, 1'b0, 1'b0);
    checkState("crc");

    $display("[TB] overflow, then load with same-edge release");
    sendPacket(2'd0, 8'h03, 1'b0, 1'b0, 1'b0);
    sendPacket(2'd0, 8'h04, 1'b0, 1'b0, 1'b0);
    checkState("ovf");
    sendPacket(2'd0, 8'h05, 1'b0, 1'b1, 1'b0);
    checkState("swap");
    releaseHeld();

    $display("[TB] foreign VC beat mid-packet");
    sendPacket(2'd0, 8'h06, 1'b0, 1'b0, 1'b1);
    checkState("drop");
    releaseHeld();

    $display("[TB] header on disabled VC2");
    applyStimulus(1'b1, 2'd2, {48'h123456789ABC, 8'h07, 8'h7E});
    my_mipi_rx_VALID = 1'b0;
    checkOutput("vc2_busy", 128'(busy), 128'(0));
    applyStimulus(1'b0, 2'd0, 64'd0);
    checkState("vc2");

    $display("[TB] randomized packets");
    vc_ena = 4'b1011;
    for (int i = 0; i < 24; i++) begin
      sendPacket(vcs[$urandom_range(0, 2)], 8'($urandom), ($urandom_range(0, 3) == 0),
                 bit'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      checkState("rand");
      if ($urandom_range(0, 1) == 1) releaseHeld();
    end

    $display("[TB] timeout");
    applyStimulus(1'b1, 2'd0, {48'h0, 8'h09, 8'h7E});
    applyStimulus(1'b1, 2'd0, {$urandom(), $urandom()});
    my_mipi_rx_VALID = 1'b0;
    exp_avail = 1'b0;
    repeat (TIMEOUT - 1) applyStimulus(1'b0, 2'd0, 64'd0);
    checkOutput("tmo_before_busy", 128'(busy), 128'(1));
    checkOutput("tmo_before_cnt", 128'(tmo_cnt), 128'(exp_tmo));
    applyStimulus(1'b0, 2'd0, 64'd0);
    exp_tmo++;
    checkState("tmo");

    $display("[TB] reset mid-packet with a held packet");
    if (exp_valid) releaseHeld();
    sendPacket(2'd1, 8'h0A, 1'b0, 1'b0, 1'b0);
    checkState("pre_rst");
    applyStimulus(1'b1, 2'd0, {48'h0, 8'h0B, 8'h7E});
    applyStimulus(1'b1, 2'd0, {$urandom(), $urandom()});
    rst = 1'b1;
    applyStimulus(1'b1, 2'd0, {$urandom(), $urandom()});
    checkAllZero("mid_rst");
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mipi_rx_pkt_assembler.md
# mipi_rx_pkt_assembler

Parametrised successor to the single-beat MIPI RX payload checker. It sits between the MIPI RX Interface Designer outputs and the miner/UART consumers, in the `rx_pixel_clk` domain. It assembles framed, checksummed packets of DLEN bytes from multi-beat MIPI data on a selectable set of virtual channels, and hands each packet downstream through a valid/ready holding register. Framing, checksum, timeout and overflow errors are counted.

## Interface
Parameters:
- `DLEN`, 64: payload bytes per packet, ≥1.
- `BPB`, 6: payload bytes used per beat, taken from `my_mipi_rx_DATA[8*BPB-1:0]`, 2..8.
- `SYNC`, 8'h7E: header sync byte.
- `TIMEOUT`, 1024: idle cycles mid-packet before abort, ≥2.

Ports (clock and reset first):
- `rx_pixel_clk` in 1: sole clock. All logic is on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `vc_ena` in 4: per-virtual-channel accept mask.
- `my_mipi_rx_VALID` in 1: beat qualifier.
- `my_mipi_rx_DATA` in 64: beat data; byte i is `[8i+7:8i]`.
- `my_mipi_rx_VC` in 2: virtual channel of the beat.
- `data_ready` in 1: downstream accepts the held packet.
- `data` out DLEN*8: payload; payload byte k is at `[8k+7:8k]`.
- `data_vc` out 2: VC of the held packet.
- `data_seq` out 8: sequence byte of the held packet.
- `data_valid` out 1: holding register full.
- `data_available` out 1: one-cycle pulse when a packet is loaded.
- `busy` out 1: assembler not IDLE.
- `crc_err_cnt`, `drop_cnt`, `ovf_cnt`, `tmo_cnt` out 8 each: saturating error counters.

## Operation
- NBEATS = ceil(DLEN/BPB). A packet is one header beat, then NBEATS payload beats, then one trailer beat. All are beats with VALID=1 on the same VC.
- Header beat: byte0 == SYNC; byte1 = sequence number; other bytes are ignored.
- Trailer beat: byte0 = XOR of all DLEN payload bytes.
- In the last payload beat, bytes at index ≥ DLEN − (NBEATS−1)·BPB are ignored and are not included in the checksum.
- State IDLE: on a VALID beat with byte0==SYNC and `vc_ena[VC]`=1, latch VC and seq, clear beat_cnt and the running XOR, go to PAYLOAD. All other beats are ignored silently.
- State PAYLOAD: each VALID beat on the latched VC writes BPB bytes at offset beat_cnt·BPB, updates the XOR, and increments beat_cnt. After beat NBEATS−1 is written, go to CHECK.
- State CHECK: on a VALID beat on the latched VC, compare byte0 with the XOR:
  - Match and holding register free (or `data_valid` && `data_ready` this cycle): load data/vc/seq, go to IDLE.
  - Match and holding register full, not released: `ovf_cnt`++, packet dropped, go to IDLE.
  - Mismatch: `crc_err_cnt`++, go to IDLE.
- In PAYLOAD or CHECK, a VALID beat on a different VC is not consumed, `drop_cnt`++, and the state is unchanged.
- Timeout: an idle counter counts cycles with no consumed beat in PAYLOAD/CHECK. When it reaches TIMEOUT: `tmo_cnt`++, go to IDLE. Partial data is discarded and the holding register is untouched.
- Holding register: `data_valid` is set on load and cleared on `data_valid && data_ready`. Simultaneous clear and load leaves it set with the new contents. `data`/`data_vc`/`data_seq` are stable while `data_valid`=1 and not released.
- Counters saturate at 8'hFF.
- A header beat seen in PAYLOAD/CHECK on the latched VC is treated as data. There is no resync except by timeout or completion.

## Timing
- Reset: state IDLE, all outputs 0 (`data`, `data_vc`, `data_seq`, `data_valid`, `data_available`, `busy`, all counters). Reset mid-packet discards everything, including the held packet.
- `busy` is registered: high from the cycle after the header is accepted until the cycle after the trailer, abort or timeout.
- Latency: a good trailer sampled at edge N gives `data_valid`=1 and `data_available`=1 after edge N. `data_available` drops after edge N+1.
- Minimum packet duration: NBEATS+2 consecutive VALID cycles. Back-to-back packets are allowed: a header may arrive in the cycle immediately after the trailer.
- Ready: `data_ready` is sampled only while `data_valid`=1, and the release takes effect on the same edge.

## Test plan
- DLEN=6, BPB=6, vc_ena=4'b0001. Beats on VC0: header 48'h…017E, payload 48'h060504030201, trailer byte0 0x07. Required: after the trailer edge, `data`=48'h060504030201, `data_seq`=0x01, `data_valid`=1, a 1-cycle `data_available` pulse; `crc_err_cnt`=0.
- Same packet with trailer 0x08 -> `data_valid` stays 0, `crc_err_cnt`=1, `busy` returns to 0.
- DLEN=10, BPB=6. Payload beats 0x0A..0x05 then 0x10,0x0F,0x0E,0x0D plus junk 0xAAAA, trailer = XOR of the 10 bytes. Required: `data`=80'h0D0E0F10_05060708090A; junk bytes are ignored in both data and checksum.
- Two good packets with `data_ready`=0 -> the first packet is held, `ovf_cnt`=1. Repeat with `data_ready`=1 on the trailer cycle of the second packet -> the second packet is loaded and `data_valid` remains 1.
- Header on VC0, then a beat on VC1 mid-packet -> `drop_cnt`=1 and the packet still completes correctly. A header on VC2 with vc_ena[2]=0 -> ignored, no counter changes.
- TIMEOUT=16: header plus one payload beat, then VALID low for 16 cycles -> `tmo_cnt`=1, `busy`=0. Assert `rst` mid-packet -> all outputs 0 on the next edge.
